// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit: FSM state
// encodings (also exported on the debug `state` port), opcode constants,
// internal ALU-op classes, ALU control codes, datapath mux select codes,
// immediate format codes and ALU flag bit positions. Also holds the ALU
// function decoder, which is shared by every user of these codes.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // FSM states. The encodings are visible on the debug port, so keep them stable.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR_T   = 4'd10,
    S_JALR_L   = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Internal ALU operation class chosen by the FSM
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // ALU control codes presented to the datapath ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU source B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Writeback / PC result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Bit positions inside flags = {n, z, c, v}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ALU decoder. SUB only for R-type (op[5]=1): I-type addi has no funct7,
  // so its instr[30] is immediate data. SRA/SRL split applies to both types.
  function automatic logic [3:0] alu_decode(input alu_op_e    alu_op,
                                            input logic [2:0] funct3,
                                            input logic       funct7b5,
                                            input logic       op5);
    logic [3:0] ctl;
    case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ctl = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctl = ALU_SLL;
          3'b010:  ctl = ALU_SLT;
          3'b011:  ctl = ALU_SLTU;
          3'b100:  ctl = ALU_XOR;
          3'b101:  ctl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctl = ALU_OR;
          default: ctl = ALU_AND;
        endcase
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Unified memory port handshake between the control unit and memory.
//   mem_req   : access valid (controller -> memory)
//   mem_write : store strobe, only meaningful with mem_req
//   adr_src   : address select for the datapath, 0 = PC, 1 = ALUOut
//   mem_ready : access complete this cycle (memory -> controller)
// master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_branch_eval.sv
// ---------------------------------------------------------------------------
// mc_branch_eval
// Branch condition evaluation from the ALU flags of rs1 - rs2.
//   flags  in  4  {n, z, c, v}; c=1 means no borrow
//   funct3 in  3  branch kind
//   taken  out 1  branch condition holds
// funct3 010/011 are not branches and never report taken.
// ---------------------------------------------------------------------------
module mc_branch_eval
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] funct3,
  output logic       taken
);

  logic lt_signed;

  always_comb begin
    lt_signed = flags[FLAG_N] ^ flags[FLAG_V];
    taken     = 1'b0;
    case (funct3)
      3'b000:  taken = flags[FLAG_Z];     // beq
      3'b001:  taken = !flags[FLAG_Z];    // bne
      3'b100:  taken = lt_signed;         // blt
      3'b101:  taken = !lt_signed;        // bge
      3'b110:  taken = !flags[FLAG_C];    // bltu: borrow means rs1 < rs2
      3'b111:  taken = flags[FLAG_C];     // bgeu
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Multicycle RV32I control unit. An FSM steps through fetch, decode,
// execute and writeback over a shared datapath and a unified memory port,
// and drives all datapath enables and mux selects.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   op/funct3/funct7b5 registered instruction fields
//   flags              {n,z,c,v} of the current ALU result
//   mem                memory handshake (master modport)
//   pc_write, ir_write, reg_write      datapath register enables
//   result_src, alu_src_a, alu_src_b  datapath mux selects
//   imm_src, alu_control              immediate format / ALU operation
//   load_type, store_type             access size hints from funct3
//   illegal_instr, bus_error          sticky trap causes
//   state                             current FSM state (debug)
//
// Parameters:
//   MEM_HANDSHAKE 1 = memory states wait for mem_ready, 0 = single cycle
//   MEM_TIMEOUT   wait-cycle limit before a bus-error trap, 0 = none
//   TO_W          wait counter width, MEM_TIMEOUT must fit in it
// ---------------------------------------------------------------------------
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_TIMEOUT   = 0,
  parameter int unsigned TO_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  multicycle_controller_if.master mem,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic [1:0] load_type,
  output logic       store_type,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam logic [TO_W-1:0] TIMEOUT_LIM = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] WAIT_MAX    = {TO_W{1'b1}};

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  logic            ready;
  logic            in_mem_state;
  logic            limit_hit;
  logic            taken;
  alu_op_e         alu_op;
  logic            mem_req_raw;
  logic            mem_write_raw;
  logic            adr_src_raw;

  // Gating with rst_n keeps pc_write/ir_write low throughout reset even if
  // the memory side happens to assert mem_ready.
  assign ready = rst_n & (MEM_HANDSHAKE ? mem.mem_ready : 1'b1);

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);

  // The counter holds the number of not-ready cycles already spent in this
  // memory state; the cycle on which it equals the limit is the last chance
  // for mem_ready, which takes priority over the trap.
  assign limit_hit = (MEM_TIMEOUT != 0) && in_mem_state && !ready &&
                     (wait_q == TIMEOUT_LIM);

  mc_branch_eval u_branch_eval (
    .flags  (flags),
    .funct3 (funct3),
    .taken  (taken)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;

    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_T;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR_T:   state_d = S_JALR_L;
      S_JALR_L:   state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
    endcase

    if (limit_hit) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end

    // Saturating so a disabled timeout never wraps back to a small count.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_mem_state && !ready && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + TO_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    adr_src_raw   = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALU;
        ir_write    = ready;
        pc_write    = ready;
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm, the branch/jal target
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src_raw = 1'b1;
        mem_req_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_raw   = 1'b1;
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_JAL: begin
        // PC <- target held in ALUOut while the ALU forms the link OldPC + 4
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_JALR_T: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
      end
      S_JALR_L: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = taken;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_TRAP: begin
        // everything stays at its inactive default
      end
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:        imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      OP_JAL:          imm_src = IMM_J;
      default:         imm_src = IMM_I;
    endcase
  end

  assign alu_control = alu_decode(alu_op, funct3, funct7b5, op[5]);
  assign load_type   = funct3[1:0];
  assign store_type  = !funct3[1];   // sb/sh

  // An access in flight is withdrawn as soon as reset asserts, without
  // waiting for a clock edge.
  assign mem.mem_req   = mem_req_raw & rst_n;
  assign mem.mem_write = mem_write_raw & rst_n;
  assign mem.adr_src   = adr_src_raw;

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [2:0] en;    // {pc_write, ir_write, reg_write}
    logic [2:0] mem;   // {mem_req, mem_write, adr_src}
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] aluc;
    logic       ill;
    logic       berr;
  } exp_t;

  localparam logic [1:0] X2 = 2'bxx;
  localparam logic [3:0] X4 = 4'bxxxx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] flags;
  logic       pc_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic [1:0] load_type;
  logic       store_type, illegal_instr, bus_error;
  logic [3:0] state;

  multicycle_controller_if mem_bus ();

  multicycle_controller #(
    .MEM_HANDSHAKE (1'b1),
    .MEM_TIMEOUT   (5),
    .TO_W          (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .flags         (flags),
    .mem           (mem_bus),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .load_type     (load_type),
    .store_type    (store_type),
    .illegal_instr (illegal_instr),
    .bus_error     (bus_error),
    .state         (state)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  logic exp_ill  = 1'b0;
  logic exp_berr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] st, input logic rdy, input logic [2:0] en,
                      input logic [2:0] mem, input logic [1:0] rs, input logic [1:0] a,
                      input logic [1:0] b, input logic [3:0] aluc);
    exp_t e;
    e.st = st; e.rdy = rdy; e.en = en; e.mem = mem;
    e.rs = rs; e.a = a; e.b = b; e.aluc = aluc;
    e.ill = exp_ill; e.berr = exp_berr;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input logic rdy);
    push(S_FETCH, rdy, {rdy, rdy, 1'b0}, 3'b100, RES_ALU, SRCA_PC, SRCB_FOUR, ALU_ADD);
  endtask

  task automatic push_decode();
    push(S_DECODE, 1'b0, 3'b000, 3'b00x, X2, SRCA_OLDPC, SRCB_IMM, ALU_ADD);
  endtask

  task automatic push_aluwb();
    push(S_ALUWB, 1'b0, 3'b001, 3'b00x, RES_ALUOUT, X2, X2, X4);
  endtask

  task automatic push_trap();
    push(S_TRAP, 1'b1, 3'b000, 3'b00x, X2, X2, X2, X4);
  endtask

  // Pops one expected cycle at a time: drive its mem_ready, sample mid-cycle.
  task automatic drain(input string name);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_bus.mem_ready = e.rdy;
      #3;
      check({name, "/state"},     32'(state),             32'(e.st));
      check({name, "/pc_write"},  32'(pc_write),          32'(e.en[2]));
      check({name, "/ir_write"},  32'(ir_write),          32'(e.en[1]));
      check({name, "/reg_write"}, 32'(reg_write),         32'(e.en[0]));
      check({name, "/mem_req"},   32'(mem_bus.mem_req),   32'(e.mem[2]));
      check({name, "/mem_write"}, 32'(mem_bus.mem_write), 32'(e.mem[1]));
      if (!$isunknown(e.mem[0])) check({name, "/adr_src"}, 32'(mem_bus.adr_src), 32'(e.mem[0]));
      if (!$isunknown(e.rs))     check({name, "/result_src"}, 32'(result_src), 32'(e.rs));
      if (!$isunknown(e.a))      check({name, "/alu_src_a"}, 32'(alu_src_a), 32'(e.a));
      if (!$isunknown(e.b))      check({name, "/alu_src_b"}, 32'(alu_src_b), 32'(e.b));
      if (!$isunknown(e.aluc))   check({name, "/alu_control"}, 32'(alu_control), 32'(e.aluc));
      check({name, "/illegal_instr"}, 32'(illegal_instr), 32'(e.ill));
      check({name, "/bus_error"},     32'(bus_error),     32'(e.berr));
      cyc++;
      @(posedge clk);
      #1;
    end
    $display("txn %-10s %0d cycles", name, cyc);
  endtask

  task automatic run_branch(input string name, input logic [2:0] f3, input logic [3:0] fl,
                            input logic tk);
    op = OP_BRANCH; funct3 = f3; funct7b5 = 1'b0; flags = fl;
    push_fetch(1'b1);
    push_decode();
    push(S_BRANCH, 1'b0, {tk, 2'b00}, 3'b00x, RES_ALUOUT, SRCA_RS1, SRCB_RS2, ALU_SUB);
    drain(name);
  endtask

  // Reset asserted mid-cycle: check the asynchronous effect, then release
  // just after an edge so the next FETCH starts with a fresh wait count.
  task automatic mid_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, "/state"},         32'(state),           32'(S_FETCH));
    check({name, "/mem_req"},       32'(mem_bus.mem_req), 32'(0));
    check({name, "/illegal_instr"}, 32'(illegal_instr),   32'(0));
    check({name, "/bus_error"},     32'(bus_error),       32'(0));
    exp_ill  = 1'b0;
    exp_berr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("txn %-10s async reset", name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b0; flags = 4'b0000;
    mem_bus.mem_ready = 1'b0;
    #2;
    check("reset/state",         32'(state),           32'(S_FETCH));
    check("reset/pc_write",      32'(pc_write),        32'(0));
    check("reset/ir_write",      32'(ir_write),        32'(0));
    check("reset/reg_write",     32'(reg_write),       32'(0));
    check("reset/illegal_instr", 32'(illegal_instr),   32'(0));
    check("reset/bus_error",     32'(bus_error),       32'(0));
    check("reset/mem_req",       32'(mem_bus.mem_req), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add x3,x1,x2
    op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b0;
    push_fetch(1'b1);
    push_decode();
    push(S_EXECR, 1'b0, 3'b000, 3'b00x, X2, SRCA_RS1, SRCB_RS2, ALU_ADD);
    push_aluwb();
    drain("add");

    // sub
    op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b1;
    push_fetch(1'b1);
    push_decode();
    push(S_EXECR, 1'b0, 3'b000, 3'b00x, X2, SRCA_RS1, SRCB_RS2, ALU_SUB);
    push_aluwb();
    drain("sub");

    // lw with 3 not-ready cycles in MEMREAD
    op = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
    #1;
    check("lw/imm_src",   32'(imm_src),   32'(IMM_I));
    check("lw/load_type", 32'(load_type), 32'(2'b10));
    push_fetch(1'b1);
    push_decode();
    push(S_MEMADR, 1'b0, 3'b000, 3'b00x, X2, SRCA_RS1, SRCB_IMM, ALU_ADD);
    for (int i = 0; i < 4; i++)
      push(S_MEMREAD, (i == 3), 3'b000, 3'b101, X2, X2, X2, X4);
    push(S_MEMWB, 1'b0, 3'b001, 3'b00x, RES_RDATA, X2, X2, X4);
    drain("lw");

    // sw
    op = OP_STORE; funct3 = 3'b010;
    #1;
    check("sw/imm_src",    32'(imm_src),    32'(IMM_S));
    check("sw/store_type", 32'(store_type), 32'(0));
    push_fetch(1'b1);
    push_decode();
    push(S_MEMADR, 1'b0, 3'b000, 3'b00x, X2, SRCA_RS1, SRCB_IMM, ALU_ADD);
    push(S_MEMWRITE, 1'b1, 3'b000, 3'b111, X2, X2, X2, X4);
    drain("sw");
    funct3 = 3'b000;
    #1;
    check("sb/store_type", 32'(store_type), 32'(1));

    // branches, flags = {n,z,c,v}
    run_branch("beq_t",  3'b000, 4'b0100, 1'b1);
    run_branch("beq_nt", 3'b000, 4'b0000, 1'b0);
    run_branch("bltu_t", 3'b110, 4'b0000, 1'b1);
    run_branch("bgeu_nt", 3'b111, 4'b0000, 1'b0);
    run_branch("blt_nt", 3'b100, 4'b1001, 1'b0);
    run_branch("bge_t",  3'b101, 4'b1001, 1'b1);
    run_branch("f3_010", 3'b010, 4'b0100, 1'b0);

    // jal
    op = OP_JAL; funct3 = 3'b000;
    #1;
    check("jal/imm_src", 32'(imm_src), 32'(IMM_J));
    push_fetch(1'b1);
    push_decode();
    push(S_JAL, 1'b0, 3'b100, 3'b00x, RES_ALUOUT, SRCA_OLDPC, SRCB_FOUR, ALU_ADD);
    push_aluwb();
    drain("jal");

    // jalr
    op = OP_JALR; funct3 = 3'b000;
    push_fetch(1'b1);
    push_decode();
    push(S_JALR_T, 1'b0, 3'b100, 3'b00x, RES_ALU, SRCA_RS1, SRCB_IMM, ALU_ADD);
    push(S_JALR_L, 1'b0, 3'b000, 3'b00x, X2, SRCA_OLDPC, SRCB_FOUR, ALU_ADD);
    push_aluwb();
    drain("jalr");

    // lui / auipc
    op = OP_LUI;
    #1;
    check("lui/imm_src", 32'(imm_src), 32'(IMM_U));
    push_fetch(1'b1);
    push_decode();
    push(S_LUI, 1'b0, 3'b000, 3'b00x, X2, SRCA_ZERO, SRCB_IMM, ALU_ADD);
    push_aluwb();
    drain("lui");
    op = OP_AUIPC;
    push_fetch(1'b1);
    push_decode();
    push(S_AUIPC, 1'b0, 3'b000, 3'b00x, X2, SRCA_OLDPC, SRCB_IMM, ALU_ADD);
    push_aluwb();
    drain("auipc");

    // illegal opcode: sticky trap, cleared only by reset
    op = 7'b0000000;
    push_fetch(1'b1);
    push_decode();
    exp_ill = 1'b1;
    push_trap();
    push_trap();
    push_trap();
    drain("illegal");
    mid_reset("ill_rst");

    // reset while a load is waiting in MEMREAD
    op = OP_LOAD; funct3 = 3'b010;
    push_fetch(1'b1);
    push_decode();
    push(S_MEMADR, 1'b0, 3'b000, 3'b00x, X2, SRCA_RS1, SRCB_IMM, ALU_ADD);
    push(S_MEMREAD, 1'b0, 3'b000, 3'b101, X2, X2, X2, X4);
    drain("lw_hold");
    check("lw_hold/mem_req", 32'(mem_bus.mem_req), 32'(1));
    mid_reset("lw_rst");

    // timeout: 5 not-ready waits, then the limit cycle also not ready -> TRAP
    op = OP_ITYPE; funct3 = 3'b101; funct7b5 = 1'b1;
    for (int i = 0; i < 6; i++) push_fetch(1'b0);
    exp_berr = 1'b1;
    push_trap();
    push_trap();
    drain("timeout");
    mid_reset("to_rst");

    // ready arrives on the limit cycle: normal fetch (srai)
    for (int i = 0; i < 5; i++) push_fetch(1'b0);
    push_fetch(1'b1);
    push_decode();
    push(S_EXECI, 1'b0, 3'b000, 3'b00x, X2, SRCA_RS1, SRCB_IMM, ALU_SRA);
    push_aluwb();
    drain("limit_rdy");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
